// File: rtl/fp_posit_pkg.sv
// Shared types and constants for the FP16 x posit multiplier sequencer.
package fp_posit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int MANT_W     = 14;
  localparam int MIN_PREC   = 2;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [MANT_W-1:0]     mant;
  } mul_result_t;

  // Precisions below MIN_PREC or above the multiplier's width are pinned to the nearest legal value.
  function automatic logic [3:0] clamp_prec(input logic [3:0] p, input logic [3:0] max_p);
    if (p < 4'(MIN_PREC)) return 4'(MIN_PREC);
    if (p > max_p) return max_p;
    return p;
  endfunction

endpackage

// File: rtl/posit_bit_serializer.sv
// Holds a posit weight and presents it one bit at a time, MSB-first from bit P-1 down to bit 0.
module posit_bit_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [3:0]   prec,
  input  logic [W-1:0] data,
  output logic         ser_bit,
  output logic         ser_last
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     data_q;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      idx    <= '0;
    end else if (load) begin
      data_q <= data;
      idx    <= IDX_W'(prec - 4'd1);
    end else if (shift && (idx != '0)) begin
      idx <= idx - 1'b1;
    end
  end

  assign ser_bit  = data_q[idx];
  assign ser_last = (idx == '0);

endmodule

// File: rtl/fp_posit_mul_seq.sv
// Sequencer for the bit-serial FP16 x posit multiplier: configures precision, streams weight bits,
// captures the result (or gives up after a timeout) and hands it downstream.
module fp_posit_mul_seq
  import fp_posit_pkg::*;
#(
  parameter int ACT_WIDTH    = 16,
  parameter int MAX_PREC     = 8,
  parameter int DONE_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [3:0]           cfg_precision,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [MAX_PREC-1:0]  in_weight,
  input  logic                 in_last,
  output logic                 mul_set,
  output logic [3:0]           mul_precision,
  output logic                 mul_valid,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic                 mul_w,
  input  logic                 mul_sign,
  input  logic [4:0]           mul_exp,
  input  logic [13:0]          mul_mant,
  input  logic                 mul_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [4:0]           out_exp,
  output logic [13:0]          out_mant,
  output logic                 out_last,
  output logic                 out_timeout,
  output logic                 busy
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  state_t               state;
  logic [3:0]           prec_reg;
  logic [ACT_WIDTH-1:0] act_reg;
  logic                 last_reg;
  logic                 cfg_rdy_q;
  logic [TMO_W-1:0]     tmo_cnt;
  mul_result_t          res_q;
  logic                 res_last_q;
  logic                 res_tmo_q;
  logic                 ser_bit;
  logic                 ser_last;
  logic                 cfg_fire;
  logic                 in_fire;
  logic                 out_fire;

  // All three ports use valid/ready: a transfer happens on a rising clk edge where both are high;
  // the source holds its payload stable while valid is high and ready is low.
  assign in_ready  = cfg_rdy_q && (prec_reg != 4'd0) && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_rdy_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = (state == ST_HOLD) && out_ready;

  posit_bit_serializer #(.W(MAX_PREC)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (in_fire),
    .shift    (state == ST_STREAM),
    .prec     (prec_reg),
    .data     (in_weight),
    .ser_bit  (ser_bit),
    .ser_last (ser_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prec_reg   <= 4'd0;
      act_reg    <= '0;
      last_reg   <= 1'b0;
      cfg_rdy_q  <= 1'b0;
      tmo_cnt    <= '0;
      res_q      <= '0;
      res_last_q <= 1'b0;
      res_tmo_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            prec_reg  <= clamp_prec(cfg_precision, 4'(MAX_PREC));
            cfg_rdy_q <= 1'b0;
            state     <= ST_SET;
          end else if (in_fire) begin
            act_reg   <= in_act;
            last_reg  <= in_last;
            cfg_rdy_q <= 1'b0;
            state     <= ST_STREAM;
          end else begin
            cfg_rdy_q <= 1'b1;
          end
        end
        ST_SET: begin
          cfg_rdy_q <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_STREAM: begin
          if (ser_last) begin
            tmo_cnt <= '0;
            // A done that lands on the final bit is taken straight away.
            if (mul_done) begin
              res_q      <= '{sign: mul_sign, exp: mul_exp, mant: mul_mant};
              res_last_q <= last_reg;
              res_tmo_q  <= 1'b0;
              state      <= ST_HOLD;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mul_done || (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1))) begin
            res_q      <= '{sign: mul_sign, exp: mul_exp, mant: mul_mant};
            res_last_q <= last_reg;
            res_tmo_q  <= !mul_done;
            state      <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_fire) begin
            cfg_rdy_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          cfg_rdy_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready     = cfg_rdy_q;
  assign mul_set       = (state == ST_SET);
  assign mul_precision = prec_reg;
  assign mul_valid     = (state == ST_STREAM);
  assign mul_act       = act_reg;
  assign mul_w         = (state == ST_STREAM) && ser_bit;
  assign out_valid     = (state == ST_HOLD);
  assign out_sign      = res_q.sign;
  assign out_exp       = res_q.exp;
  assign out_mant      = res_q.mant;
  assign out_last      = res_last_q;
  assign out_timeout   = res_tmo_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_posit_mul_seq.sv
// Directed bench for fp_posit_mul_seq with a hand-driven multiplier stub and an expected-bit queue.
module tb_fp_posit_mul_seq;

  localparam int ACT_WIDTH    = 16;
  localparam int MAX_PREC     = 8;
  localparam int DONE_TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid = 1'b0;
  logic [3:0]           cfg_precision = 4'd0;
  logic                 cfg_ready;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] in_act = '0;
  logic [MAX_PREC-1:0]  in_weight = '0;
  logic                 in_last = 1'b0;
  logic                 mul_set;
  logic [3:0]           mul_precision;
  logic                 mul_valid;
  logic [ACT_WIDTH-1:0] mul_act;
  logic                 mul_w;
  logic                 mul_sign = 1'b0;
  logic [4:0]           mul_exp = '0;
  logic [13:0]          mul_mant = '0;
  logic                 mul_done = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_sign;
  logic [4:0]           out_exp;
  logic [13:0]          out_mant;
  logic                 out_last;
  logic                 out_timeout;
  logic                 busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [0:0] exp_q[$];

  fp_posit_mul_seq #(
    .ACT_WIDTH(ACT_WIDTH), .MAX_PREC(MAX_PREC), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_precision(cfg_precision), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight), .in_last(in_last),
    .mul_set(mul_set), .mul_precision(mul_precision), .mul_valid(mul_valid), .mul_act(mul_act), .mul_w(mul_w),
    .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_mant(mul_mant), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_last(out_last), .out_timeout(out_timeout), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({cfg_ready, in_ready, mul_set, mul_valid, mul_w, out_valid, out_last, out_timeout, busy}), 0);
    check({tag, "_mul_precision"}, 32'(mul_precision), 0);
    check({tag, "_mul_act"}, 32'(mul_act), 0);
    check({tag, "_result"}, 32'({out_sign, out_exp, out_mant}), 0);
  endtask

  task automatic drive_result(input logic done, input logic s, input logic [4:0] e, input logic [13:0] m);
    mul_done = done;
    mul_sign = s;
    mul_exp  = e;
    mul_mant = m;
  endtask

  // driver: configuration transfer followed by the one-cycle SET strobe
  task automatic do_cfg(input logic [3:0] p, input logic [3:0] exp_p, input bit with_in);
    int n = 0;
    while (!cfg_ready && n < 5) begin tick(); n++; end
    check("cfg_ready", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_precision = p;
    if (with_in) in_valid = 1'b1;
    #1;
    if (with_in) check("cfg_priority_in_ready", 32'(in_ready), 0);
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("set_strobe", 32'(mul_set), 1);
    check("set_precision", 32'(mul_precision), 32'(exp_p));
    check("set_cfg_ready", 32'(cfg_ready), 0);
    tick();
    check("set_one_cycle", 32'(mul_set), 0);
    check("set_back_idle", 32'(busy), 0);
    check("set_hold_precision", 32'(mul_precision), 32'(exp_p));
  endtask

  // driver + scoreboard for one operand; done_at: -1 never, 0 with last bit, n = nth wait cycle
  task automatic run_op(input logic [15:0] act, input logic [7:0] w, input logic last, input int prec,
                        input int done_at, input int hold,
                        input logic s, input logic [4:0] e, input logic [13:0] m);
    bit tmo = (done_at < 0);
    int n = 0;
    int w_cnt = 0;
    int exp_wait = tmo ? DONE_TIMEOUT : done_at;
    exp_q.delete();
    for (int i = prec - 1; i >= 0; i--) exp_q.push_back(w[i]);
    if (tmo) drive_result(1'b0, s, e, m);
    else     drive_result(1'b0, ~s, ~e, ~m);
    in_act = act; in_weight = w; in_last = last; in_valid = 1'b1;
    #1;
    check("in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; in_act = ~act; in_weight = ~w; in_last = ~last;
    while (mul_valid && n < 20) begin
      if (exp_q.size() == 0) check("extra_bit", 32'(mul_valid), 0);
      else check("mul_w", 32'(mul_w), 32'(exp_q.pop_front()));
      check("mul_act", 32'(mul_act), 32'(act));
      check("stream_busy", 32'({busy, in_ready, cfg_ready}), 32'(3'b100));
      if (n == prec - 1 && done_at == 0) drive_result(1'b1, s, e, m);
      n++;
      tick();
      if (!tmo) drive_result(1'b0, ~s, ~e, ~m);
    end
    check("stream_len", 32'(n), 32'(prec));
    check("bits_left", 32'(exp_q.size()), 0);
    while (!out_valid && w_cnt < 12) begin
      check("wait_quiet", 32'({mul_valid, mul_w, busy}), 32'(3'b001));
      w_cnt++;
      if (w_cnt == done_at) drive_result(1'b1, s, e, m);
      tick();
      if (!tmo) drive_result(1'b0, ~s, ~e, ~m);
    end
    check("wait_cycles", 32'(w_cnt), 32'(exp_wait));
    for (int h = 0; h <= hold; h++) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_result", 32'({out_sign, out_exp, out_mant}), 32'({s, e, m}));
      check("hold_flags", 32'({out_timeout, out_last}), 32'({tmo, last}));
      if (h == hold) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("release_idle", 32'({out_valid, busy, cfg_ready}), 32'(3'b001));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;

    // unconfigured: operands must be refused
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("unconf_in_ready", 32'(in_ready), 0);
      check("unconf_mul_valid", 32'(mul_valid), 0);
    end
    check("unconf_cfg_ready", 32'(cfg_ready), 1);
    in_valid = 1'b0;

    do_cfg(4'd8, 4'd8, 1'b0);
    run_op(16'h3C00, 8'hB5, 1'b0, 8, 1, 0, 1'b0, 5'h10, 14'h2001);

    do_cfg(4'd4, 4'd4, 1'b1);
    run_op(16'h4500, 8'h0A, 1'b0, 4, 2, 5, 1'b0, 5'h0F, 14'h0400);

    do_cfg(4'd12, 4'd8, 1'b0);
    run_op(16'hC200, 8'h5A, 1'b1, 8, -1, 2, 1'b1, 5'h07, 14'h1234);

    do_cfg(4'd1, 4'd2, 1'b0);
    run_op(16'h0001, 8'hF2, 1'b1, 2, 0, 0, 1'b1, 5'h1F, 14'h3FFF);

    // asynchronous reset in the middle of a stream
    do_cfg(4'd8, 4'd8, 1'b0);
    in_act = 16'h1234; in_weight = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("pre_reset_stream", 32'(mul_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_in_ready", 32'(in_ready), 0);
      check("post_reset_quiet", 32'({mul_valid, out_valid, busy}), 0);
    end
    check("post_reset_precision", 32'(mul_precision), 0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
